// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipelined core.
// Contents:
//   - opcode values, including the halt opcode OPC_HLT
//   - fetch_state_e : fetch-stage state encoding
//   - PC_INC_DEF    : byte stride between sequential instructions
package wisc_pkg;

    localparam logic [3:0] OPC_ADD    = 4'h0;
    localparam logic [3:0] OPC_PADDSB = 4'h1;
    localparam logic [3:0] OPC_SUB    = 4'h2;
    localparam logic [3:0] OPC_XOR    = 4'h3;
    localparam logic [3:0] OPC_SLL    = 4'h4;
    localparam logic [3:0] OPC_SRA    = 4'h5;
    localparam logic [3:0] OPC_ROR    = 4'h6;
    localparam logic [3:0] OPC_LW     = 4'h8;
    localparam logic [3:0] OPC_SW     = 4'h9;
    localparam logic [3:0] OPC_LLB    = 4'hA;
    localparam logic [3:0] OPC_LHB    = 4'hB;
    localparam logic [3:0] OPC_B      = 4'hC;
    localparam logic [3:0] OPC_BR     = 4'hD;
    localparam logic [3:0] OPC_PCS    = 4'hE;
    localparam logic [3:0] OPC_HLT    = 4'hF;

    localparam int PC_INC_DEF = 2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Address-wide register with write enable and an asynchronous active-low
// reset to a parameterised value. Used for the fetch PC and for the
// pending redirect target.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_wen      : load i_d on the next rising edge
//   i_d        : next value
//   o_q        : current value
module pc_reg
    import wisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_d,
    output logic [ADDR_W-1:0] o_q
);

    logic [ADDR_W-1:0] r_q;

    // Hold the address; load when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_PC;
        end else if (i_wen) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/rdy handshake to a
// variable-latency instruction memory and hands one instruction at a time
// to decode through a valid/stall slot. Handles branch redirect, HLT and
// halt release.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   imem_req/addr         : fetch request and address (held until rdy)
//   imem_rdy/data         : one-cycle response and returned instruction
//   id_stall              : decode cannot accept; slot holds
//   br_taken/br_target    : one-cycle redirect from execute
//   if_valid/inst/pc      : slot contents
//   if_pc_next            : if_pc + PC_INC
//   pc                    : current fetch PC
//   halted                : stopped on HLT with the slot drained
module fetch_unit
    import wisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter int                OPC_W    = 4,
    parameter logic [OPC_W-1:0]  HLT_OPC  = OPC_W'(OPC_HLT),
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = PC_INC_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [INST_W-1:0] imem_data,
    input  logic              id_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_next,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_e      r_state;
    logic              r_started;   // request issued in an earlier cycle, still open
    logic              r_if_valid;
    logic [INST_W-1:0] r_if_inst;
    logic [ADDR_W-1:0] r_if_pc;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_pc_wen;
    logic [ADDR_W-1:0] w_pc_d;
    logic              w_tgt_wen;
    logic              w_slot_free;
    logic              w_consume;
    logic              w_req;
    logic              w_accept;
    logic              w_defer;
    logic [OPC_W-1:0]  w_opc;
    logic              w_is_hlt;

    assign w_slot_free = ~r_if_valid | ~id_stall;
    assign w_consume   = r_if_valid & ~id_stall;
    assign w_opc       = imem_data[INST_W-1 -: OPC_W];
    assign w_is_hlt    = (w_opc == HLT_OPC);

    // Request generation: once raised in FETCH it stays up until rdy.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_FETCH: w_req = r_started | w_slot_free;
            ST_FLUSH: w_req = 1'b1;
            ST_HOLD:  w_req = 1'b0;
            ST_HALT:  w_req = 1'b0;
            default:  w_req = 1'b0;
        endcase
    end

    assign w_accept = (r_state == ST_FETCH) & w_req & imem_rdy;
    // A redirect that meets an unanswered request must wait for its reply.
    assign w_defer  = w_req & ~imem_rdy;

    // Next PC and redirect-target write control.
    always_comb begin
        w_pc_wen  = 1'b0;
        w_pc_d    = w_pc;
        w_tgt_wen = 1'b0;
        if (br_taken) begin
            if (w_defer) begin
                w_tgt_wen = 1'b1;
            end else begin
                w_pc_wen = 1'b1;
                w_pc_d   = br_target;
            end
        end else if (w_accept) begin
            if (w_is_hlt) begin
                w_pc_wen = 1'b0;   // PC parks on the HLT address
            end else begin
                w_pc_wen = 1'b1;
                w_pc_d   = w_pc + ADDR_W'(PC_INC);
            end
        end else if ((r_state == ST_FLUSH) && imem_rdy) begin
            w_pc_wen = 1'b1;
            w_pc_d   = w_tgt;
        end else begin
            w_pc_wen = 1'b0;
        end
    end

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_wen (w_pc_wen),
        .i_d   (w_pc_d),
        .o_q   (w_pc)
    );

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC('0)) u_tgt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_wen (w_tgt_wen),
        .i_d   (br_target),
        .o_q   (w_tgt)
    );

    // Fetch state machine, slot contents and open-request tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_started  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_inst  <= '0;
            r_if_pc    <= '0;
        end else if (br_taken) begin
            r_if_valid <= 1'b0;
            r_started  <= 1'b0;
            r_state    <= w_defer ? ST_FLUSH : ST_FETCH;
        end else begin
            if (w_consume) begin
                r_if_valid <= 1'b0;
            end else begin
                r_if_valid <= r_if_valid;
            end
            case (r_state)
                ST_FETCH: begin
                    if (w_accept) begin
                        // The slot is always free here, so the load wins.
                        r_if_valid <= 1'b1;
                        r_if_inst  <= imem_data;
                        r_if_pc    <= w_pc;
                        r_started  <= 1'b0;
                        r_state    <= w_is_hlt ? ST_HALT : ST_FETCH;
                    end else if (w_req) begin
                        r_started  <= 1'b1;
                    end else begin
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!id_stall) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_FLUSH: begin
                    // Wrong-path reply is dropped; the PC takes the saved target.
                    if (imem_rdy) begin
                        r_state   <= ST_FETCH;
                        r_started <= 1'b0;
                    end else begin
                        r_state   <= ST_FLUSH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // In FLUSH the PC has not moved yet, so it is still the old request address.
    assign imem_req   = w_req;
    assign imem_addr  = w_pc;
    assign pc         = w_pc;
    assign if_valid   = r_if_valid;
    assign if_inst    = r_if_inst;
    assign if_pc      = r_if_pc;
    assign if_pc_next = r_if_pc + ADDR_W'(PC_INC);
    assign halted     = (r_state == ST_HALT) & ~r_if_valid;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_rdy;
    logic [15:0] imem_addr, imem_data;
    logic        id_stall, br_taken;
    logic [15:0] br_target;
    logic        if_valid, halted;
    logic [15:0] if_inst, if_pc, if_pc_next, pc;

    logic        w_req, w_valid, w_halted;
    logic [15:0] w_addr, w_inst, w_ifpc, w_ifpcn, w_pc;

    fetch_unit #(.ADDR_W(16), .INST_W(16), .OPC_W(4), .HLT_OPC(4'hF),
                 .RESET_PC(16'h0000), .PC_INC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_pc_next(if_pc_next), .pc(pc), .halted(halted)
    );

    // Second copy starting near the top of the address space, zero-wait memory.
    fetch_unit #(.ADDR_W(16), .INST_W(16), .OPC_W(4), .HLT_OPC(4'hF),
                 .RESET_PC(16'hFFFC), .PC_INC(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdy(w_req), .imem_data({4'h1, w_addr[11:0]}),
        .id_stall(1'b0), .br_taken(1'b0), .br_target(16'h0000),
        .if_valid(w_valid), .if_inst(w_inst), .if_pc(w_ifpc),
        .if_pc_next(w_ifpcn), .pc(w_pc), .halted(w_halted)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_deliv = 0;
    logic [15:0] mem [256];
    int          lat_cfg = 1;      // 0 = random latency 1..4
    bit          busy    = 1'b0;
    int          cnt     = 0;
    logic [15:0] busy_addr = 16'h0;
    logic [15:0] exp_pc  = 16'h0;  // next address decode should receive
    bit          halted_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem[a[8:1]];
    endfunction

    // One clock cycle: memory model answers, scoreboard observes, edge passes.
    task automatic step();
        logic [15:0] w;
        #1;
        if (!rst_n) begin
            busy = 1'b0; imem_rdy = 1'b0; exp_pc = 16'h0; halted_mode = 1'b0;
        end else begin
            imem_rdy = 1'b0;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1; busy_addr = imem_addr;
                    cnt = (lat_cfg == 0) ? int'($urandom_range(4, 1)) : lat_cfg;
                end else begin
                    check_eq("addr_stable", imem_addr, busy_addr);
                end
                cnt--;
                if (cnt == 0) begin
                    imem_rdy = 1'b1; imem_data = mem_word(busy_addr); busy = 1'b0;
                end else begin
                    imem_data = 16'($urandom);
                end
            end else if (busy) begin
                check_eq("req_held", imem_req, 1);
            end
            #1;
            if (halted_mode) begin
                check_eq("halted", halted, 1);
                check_eq("halt_pc", pc, exp_pc);
            end else begin
                check_eq("halted", halted, 0);
            end
            if (br_taken) begin
                exp_pc = br_target; halted_mode = 1'b0;
            end else if (if_valid && !id_stall) begin
                n_deliv++;
                w = mem_word(exp_pc);
                check_eq("sb_pc", if_pc, exp_pc);
                check_eq("sb_inst", if_inst, w);
                check_eq("sb_pc_next", if_pc_next, exp_pc + 16'd2);
                if (w[15:12] == 4'hF) halted_mode = 1'b1;
                else exp_pc = exp_pc + 16'd2;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;
        imem_rdy = 1'b0; imem_data = 16'h0;
        repeat (2) step();
        check_eq("rst_valid", if_valid, 0);
        check_eq("rst_inst", if_inst, 0);
        check_eq("rst_ifpc", if_pc, 0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_w_pc", w_pc, 16'hFFFC);
        rst_n = 1'b1;
    endtask

    logic [15:0] t1_inst [3];
    logic [15:0] t1_pc   [3];
    logic [15:0] t1_wpc  [3];
    logic [7:0]  r8;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789; mem[3] = 16'h4ABC;
        mem[4] = 16'hF000; mem[8] = 16'h6666; mem[9] = 16'h6777; mem[32] = 16'h5555;
        t1_inst[0] = 16'h1123; t1_inst[1] = 16'h2456; t1_inst[2] = 16'h3789;
        t1_pc[0] = 16'h0000; t1_pc[1] = 16'h0002; t1_pc[2] = 16'h0004;
        t1_wpc[0] = 16'hFFFC; t1_wpc[1] = 16'hFFFE; t1_wpc[2] = 16'h0000;

        // Zero-wait streaming, plus the wrap-around copy.
        do_reset();
        lat_cfg = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_valid", if_valid, 1);
            check_eq("t1_ifpc", if_pc, t1_pc[i]);
            check_eq("t1_inst", if_inst, t1_inst[i]);
            check_eq("t1_pcnext", if_pc_next, t1_pc[i] + 16'd2);
            check_eq("wrap_ifpc", w_ifpc, t1_wpc[i]);
            check_eq("wrap_inst", w_inst, {4'h1, t1_wpc[i][11:0]});
            check_eq("wrap_valid", w_valid, 1);
        end
        check_eq("wrap_pcnext", w_ifpcn, 16'h0002);
        check_eq("wrap_pc", w_pc, 16'h0002);
        check_eq("wrap_halted", w_halted, 0);

        // Latency 3: request held with stable address, slot fills after rdy.
        do_reset();
        lat_cfg = 3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t2_req", imem_req, 1);
            check_eq("t2_addr", imem_addr, 0);
            check_eq("t2_valid", if_valid, 0);
            step();
        end
        check_eq("t2_valid_after", if_valid, 1);
        check_eq("t2_ifpc", if_pc, 0);
        check_eq("t2_next_addr", imem_addr, 2);

        // Decode stall with a full slot parks fetch in HOLD.
        id_stall = 1'b1; lat_cfg = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t3_req_low", imem_req, 0);
            check_eq("t3_inst_held", if_inst, 16'h1123);
            step();
        end
        id_stall = 1'b0;
        #1; check_eq("t3_hold_req", imem_req, 0);
        step();
        #1;
        check_eq("t3_resume_req", imem_req, 1);
        check_eq("t3_resume_addr", imem_addr, 2);

        // Redirect one cycle into a 3-cycle request at address 6.
        step(); step();
        #1; check_eq("t4_addr6", imem_addr, 6);
        lat_cfg = 3;
        step();
        br_taken = 1'b1; br_target = 16'h0040;
        step();
        br_taken = 1'b0;
        #1;
        check_eq("t4_flush_valid", if_valid, 0);
        check_eq("t4_flush_req", imem_req, 1);
        check_eq("t4_flush_addr", imem_addr, 6);
        step();
        lat_cfg = 1;
        #1;
        check_eq("t4_discard", if_valid, 0);
        check_eq("t4_new_addr", imem_addr, 16'h0040);
        step();
        check_eq("t4_ifpc", if_pc, 16'h0040);
        check_eq("t4_inst", if_inst, 16'h5555);

        // HLT at address 8, then release by redirect to 0x10.
        br_taken = 1'b1; br_target = 16'h0008;
        step();
        br_taken = 1'b0;
        #1; check_eq("t5_addr8", imem_addr, 8);
        step();
        check_eq("t5_hlt_valid", if_valid, 1);
        check_eq("t5_hlt_inst", if_inst, 16'hF000);
        check_eq("t5_pc_frozen", pc, 8);
        check_eq("t5_not_yet", halted, 0);
        step();
        check_eq("t5_halted", halted, 1);
        #1; check_eq("t5_req_low", imem_req, 0);
        step();
        check_eq("t5_pc_still", pc, 8);
        br_taken = 1'b1; br_target = 16'h0010;
        step();
        br_taken = 1'b0;
        check_eq("t5_released", halted, 0);
        #1; check_eq("t5_resume_addr", imem_addr, 16'h0010);
        step();
        check_eq("t5_ifpc", if_pc, 16'h0010);
        check_eq("t5_inst", if_inst, 16'h6666);

        // Reset in the middle of an outstanding request; late rdy ignored.
        lat_cfg = 4;
        step();
        #2; rst_n = 1'b0;
        #1;
        check_eq("t7_valid", if_valid, 0);
        check_eq("t7_inst", if_inst, 0);
        check_eq("t7_ifpc", if_pc, 0);
        check_eq("t7_pc", pc, 0);
        check_eq("t7_halted", halted, 0);
        imem_rdy = 1'b1; imem_data = 16'hDEAD;
        @(posedge clk); #1;
        imem_rdy = 1'b0;
        check_eq("t7_late_rdy", if_valid, 0);
        busy = 1'b0; exp_pc = 16'h0; halted_mode = 1'b0;
        rst_n = 1'b1; lat_cfg = 3;
        step();
        check_eq("t7_no_data", if_valid, 0);
        check_eq("t7_pc0", pc, 0);
        step(); step();
        check_eq("t7_first_valid", if_valid, 1);
        check_eq("t7_first_pc", if_pc, 0);
        check_eq("t7_first_inst", if_inst, 16'h1123);

        // Randomised traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        lat_cfg = 0; n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            id_stall  = ($urandom % 4) == 0;
            br_taken  = ($urandom % 24) == 0;
            r8        = 8'($urandom);
            br_target = {7'h0, r8, 1'b0};
            step();
        end
        check_eq("rand_progress", n_deliv > 300, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
